// File: rtl/key_step_ctrl_pkg.sv
// rtl/key_step_ctrl_pkg.sv - shared FSM encodings and key polarity for the key step controller
package key_step_ctrl_pkg;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_ARMED  = 2'd1,
        KS_REPEAT = 2'd2
    } ks_state_t;

    localparam bit KEY_ACTIVE_LOW = 1'b1;

endpackage

// File: rtl/key_step_ctrl_if.sv
// rtl/key_step_ctrl_if.sv - key input / event output bundle for the key step controller
interface key_step_ctrl_if;

    logic        key_in;
    logic        enable;
    logic        press_pulse;
    logic        release_pulse;
    logic        step_pulse;
    logic        long_press;
    logic [15:0] step_count;

    modport master (
        output key_in, enable,
        input  press_pulse, release_pulse, step_pulse, long_press, step_count
    );

    modport slave (
        input  key_in, enable,
        output press_pulse, release_pulse, step_pulse, long_press, step_count
    );

endinterface

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - key polarity fix, sample/history registers and press/release edges
module key_edge_detect #(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit RESET_PRESSED = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic rise,
    output logic fall
);

    logic pressed;
    logic pressed_s;
    logic pressed_q;

    assign pressed = ACTIVE_LOW ? ~key_in : key_in;

    // Both stages reset to "pressed" so a key held through reset gives no rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed_s <= RESET_PRESSED;
            pressed_q <= RESET_PRESSED;
        end else begin
            pressed_s <= pressed;
            pressed_q <= pressed_s;
        end
    end

    assign rise = pressed_s & ~pressed_q;
    assign fall = ~pressed_s & pressed_q;

endmodule

// File: rtl/key_step_ctrl.sv
// rtl/key_step_ctrl.sv - key event FSM: press/release/step pulses, long-press and auto-repeat
module key_step_ctrl
    import key_step_ctrl_pkg::*;
#(
    parameter bit          ACTIVE_LOW    = KEY_ACTIVE_LOW,
    parameter int unsigned LONG_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter int unsigned CNT_W         = 26
) (
    input logic            clk,
    input logic            rst_n,
    key_step_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

    logic rise;
    logic fall;

    key_edge_detect #(
        .ACTIVE_LOW   (ACTIVE_LOW),
        .RESET_PRESSED(1'b1)
    ) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .key_in(bus.key_in),
        .rise  (rise),
        .fall  (fall)
    );

    ks_state_t        state, state_d;
    logic [CNT_W-1:0] timer, timer_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             step_q, step_d;
    logic             long_q, long_d;
    logic [15:0]      count_q;

    always_comb begin
        state_d   = state;
        timer_d   = timer;
        press_d   = 1'b0;
        release_d = 1'b0;
        step_d    = 1'b0;
        if (!bus.enable) begin
            state_d = KS_IDLE;
            timer_d = '0;
        end else begin
            case (state)
                KS_IDLE: begin
                    timer_d = '0;
                    if (rise) begin
                        state_d = KS_ARMED;
                        press_d = 1'b1;
                        step_d  = 1'b1;
                    end
                end
                KS_ARMED: begin
                    // Release takes priority over a coincident long-press terminal.
                    if (fall) begin
                        state_d   = KS_IDLE;
                        timer_d   = '0;
                        release_d = 1'b1;
                    end else if (timer == LONG_TERM) begin
                        state_d = KS_REPEAT;
                        timer_d = '0;
                        step_d  = 1'b1;
                    end else begin
                        timer_d = timer + 1'b1;
                    end
                end
                KS_REPEAT: begin
                    if (fall) begin
                        state_d   = KS_IDLE;
                        timer_d   = '0;
                        release_d = 1'b1;
                    end else if (timer == REPEAT_TERM) begin
                        timer_d = '0;
                        step_d  = 1'b1;
                    end else begin
                        timer_d = timer + 1'b1;
                    end
                end
                default: begin
                    state_d = KS_IDLE;
                    timer_d = '0;
                end
            endcase
        end
        long_d = (state_d == KS_REPEAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= KS_IDLE;
            timer     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
            long_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state     <= state_d;
            timer     <= timer_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
            long_q    <= long_d;
            count_q   <= count_q + 16'(step_d);
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.step_pulse    = step_q;
    assign bus.long_press    = long_q;
    assign bus.step_count    = count_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// tb/tb_key_step_ctrl.sv - directed scoreboard bench for key_step_ctrl
module tb_key_step_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_step_ctrl_if bus ();
    key_step_ctrl_if fbus ();

    key_step_ctrl #(
        .ACTIVE_LOW(1'b1), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Fast-repeat instance used only to walk step_count through its wrap.
    key_step_ctrl #(
        .ACTIVE_LOW(1'b1), .LONG_CYCLES(2), .REPEAT_CYCLES(1), .CNT_W(4)
    ) dut_fast (
        .clk(clk), .rst_n(rst_n), .bus(fbus)
    );

    typedef struct {
        int         cyc;
        logic [2:0] ev;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   long_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [2:0] ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Event monitor: {press, release, step} compared against the scoreboard.
    always @(negedge clk) begin
        logic [2:0] ev;
        exp_t       e;
        ev = {bus.press_pulse, bus.release_pulse, bus.step_pulse};
        if (bus.long_press) long_hi++;
        if (rst_n && ev != 3'b000) begin
            if (sb.size() == 0) begin
                check_val("unexpected_pulse", {29'd0, ev}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("pulse_cycle", cyc, e.cyc);
                check_val("pulse_kind", {29'd0, ev}, {29'd0, e.ev});
            end
        end
    end

    initial begin
        int c;
        int n;
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        bus.key_in  = 1'b1;
        bus.enable  = 1'b1;
        fbus.key_in = 1'b1;
        fbus.enable = 1'b1;
        do_reset();

        check_val("reset_press", bus.press_pulse, 1'b0);
        check_val("reset_release", bus.release_pulse, 1'b0);
        check_val("reset_step", bus.step_pulse, 1'b0);
        check_val("reset_long", bus.long_press, 1'b0);
        check_val("reset_count", bus.step_count, 16'd0);

        // 1: short press of three cycles
        long_hi = 0;
        tick();
        c = cyc;
        bus.key_in = 1'b0;
        push(c + 2, 3'b101);
        repeat (3) tick();
        bus.key_in = 1'b1;
        push(c + 5, 3'b010);
        repeat (6) tick();
        check_val("t1_sb_empty", sb.size(), 0);
        check_val("t1_count", bus.step_count, 16'd1);
        check_val("t1_long_never", long_hi, 0);

        // 2: 30-cycle hold with long-press and auto-repeat
        do_reset();
        tick();
        c = cyc;
        bus.key_in = 1'b0;
        push(c + 2, 3'b101);
        for (int k = 8; k <= 28; k += 4) push(c + 2 + k, 3'b001);
        push(c + 32, 3'b010);
        wait_until(c + 9);
        check_val("t2_long_before", bus.long_press, 1'b0);
        wait_until(c + 10);
        check_val("t2_long_entry", bus.long_press, 1'b1);
        while (cyc < c + 30) tick();
        bus.key_in = 1'b1;
        wait_until(c + 31);
        check_val("t2_long_held", bus.long_press, 1'b1);
        wait_until(c + 32);
        check_val("t2_long_cleared", bus.long_press, 1'b0);
        repeat (4) tick();
        check_val("t2_sb_empty", sb.size(), 0);
        check_val("t2_count", bus.step_count, 16'd7);

        // 3: release coincides with long-press terminal
        do_reset();
        tick();
        c = cyc;
        bus.key_in = 1'b0;
        push(c + 2, 3'b101);
        repeat (8) tick();
        bus.key_in = 1'b1;
        push(c + 10, 3'b010);
        repeat (5) tick();
        check_val("t3_sb_empty", sb.size(), 0);
        check_val("t3_count", bus.step_count, 16'd1);
        check_val("t3_long", bus.long_press, 1'b0);

        // 4: async reset mid-hold, key held across deassertion
        do_reset();
        tick();
        c = cyc;
        bus.key_in = 1'b0;
        push(c + 2, 3'b101);
        push(c + 10, 3'b001);
        while (cyc < c + 12) tick();
        check_val("t4_long_pre", bus.long_press, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("t4_async_long", bus.long_press, 1'b0);
        check_val("t4_async_count", bus.step_count, 16'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_val("t4_no_press", sb.size(), 0);
        check_val("t4_count_held", bus.step_count, 16'd0);
        bus.key_in = 1'b1;
        repeat (2) tick();
        c = cyc;
        bus.key_in = 1'b0;
        push(c + 2, 3'b101);
        repeat (3) tick();
        bus.key_in = 1'b1;
        push(c + 5, 3'b010);
        repeat (5) tick();
        check_val("t4_sb_empty", sb.size(), 0);
        check_val("t4_count", bus.step_count, 16'd1);

        // 5: enable drops in REPEAT on the edge a repeat step would fire
        do_reset();
        tick();
        c = cyc;
        bus.key_in = 1'b0;
        push(c + 2, 3'b101);
        push(c + 10, 3'b001);
        while (cyc < c + 13) tick();
        check_val("t5_long_pre", bus.long_press, 1'b1);
        bus.enable = 1'b0;
        tick();
        check_val("t5_long_drop", bus.long_press, 1'b0);
        repeat (5) tick();
        bus.enable = 1'b1;
        repeat (10) tick();
        check_val("t5_no_pulses", sb.size(), 0);
        check_val("t5_count_mid", bus.step_count, 16'd2);
        bus.key_in = 1'b1;
        repeat (2) tick();
        c = cyc;
        bus.key_in = 1'b0;
        push(c + 2, 3'b101);
        repeat (3) tick();
        bus.key_in = 1'b1;
        push(c + 5, 3'b010);
        repeat (5) tick();
        check_val("t5_sb_empty", sb.size(), 0);
        check_val("t5_count", bus.step_count, 16'd3);

        // 6: step_count wrap on the fast instance
        do_reset();
        tick();
        fbus.key_in = 1'b0;
        n = 0;
        for (int i = 0; i < 70000 && n < 65536; i++) begin
            @(negedge clk);
            if (fbus.step_pulse) begin
                n++;
                if (n == 65535) check_val("t6_count_max", fbus.step_count, 16'hFFFF);
                if (n == 65536) check_val("t6_count_wrap", fbus.step_count, 16'h0000);
            end
        end
        check_val("t6_step_total", n, 65536);
        fbus.key_in = 1'b1;
        repeat (5) tick();
        check_val("t6_main_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
